// File: rtl/i2c_multi_channel_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_multi_channel_sequencer
//  Purpose  : Arbitrates NCH requester channels and breaks the granted I2C
//             transaction (START, address, N data bytes, STOP) into byte
//             commands for the bit engine. Write data, read data, completion
//             and NACK status are routed back to the owning channel.
//  Revision : 1.0  initial release
// ============================================================================
module i2c_multi_channel_sequencer #(
  parameter int    NCH   = 8,
  parameter int    ASIZE = 7,
  parameter int    DSIZE = 8,
  parameter int    LSIZE = 8,
  parameter string ARB   = "RR"
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic [NCH-1:0]         ch_req,
  input  logic [NCH-1:0]         ch_rd,
  input  logic [NCH*ASIZE-1:0]   ch_saddr,
  input  logic [NCH*LSIZE-1:0]   ch_len,
  input  logic [NCH*DSIZE-1:0]   ch_wdata,
  output logic [NCH-1:0]         ch_wready,
  output logic [NCH-1:0]         ch_rvalid,
  output logic [DSIZE-1:0]       ch_rdata,
  output logic [NCH-1:0]         ch_done,
  output logic [NCH-1:0]         ch_nack,
  output logic                   busy,
  output logic [$clog2(NCH)-1:0] grant_id,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic [2:0]             cmd_op,
  output logic [DSIZE-1:0]       cmd_data,
  input  logic                   rsp_valid,
  input  logic [DSIZE-1:0]       rsp_data,
  input  logic                   rsp_nack
);

  localparam int GW = $clog2(NCH);

  localparam logic [2:0] OP_START    = 3'd0;
  localparam logic [2:0] OP_WRITE    = 3'd1;
  localparam logic [2:0] OP_RD_ACK   = 3'd2;
  localparam logic [2:0] OP_RD_NACK  = 3'd3;
  localparam logic [2:0] OP_STOP     = 3'd4;

  // Each command state X is followed by X_W, where the command has been
  // accepted and the bit engine's response is awaited.
  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_START   = 4'd1;
  localparam logic [3:0] S_START_W = 4'd2;
  localparam logic [3:0] S_ADDR    = 4'd3;
  localparam logic [3:0] S_ADDR_W  = 4'd4;
  localparam logic [3:0] S_DATA    = 4'd5;
  localparam logic [3:0] S_DATA_W  = 4'd6;
  localparam logic [3:0] S_STOP    = 4'd7;
  localparam logic [3:0] S_STOP_W  = 4'd8;
  localparam logic [3:0] S_DONE    = 4'd9;

  logic [3:0]       state_q, state_d;
  logic [GW-1:0]    grant_q, grant_d;
  logic [GW-1:0]    last_q, last_d;
  logic             busy_q, busy_d;
  logic             rd_q, rd_d;
  logic [ASIZE-1:0] saddr_q, saddr_d;
  logic [LSIZE-1:0] cnt_q, cnt_d;
  logic             nack_flag_q, nack_flag_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic [2:0]       cmd_op_q, cmd_op_d;
  logic [DSIZE-1:0] cmd_data_q, cmd_data_d;
  logic [NCH-1:0]   wready_q, wready_d;
  logic [NCH-1:0]   rvalid_q, rvalid_d;
  logic [DSIZE-1:0] rdata_q, rdata_d;
  logic [NCH-1:0]   done_q, done_d;
  logic [NCH-1:0]   nack_q, nack_d;

  logic [GW-1:0]    winner;
  logic [DSIZE-1:0] wdata_sel;
  logic [DSIZE-1:0] addr_byte;
  logic [LSIZE-1:0] next_cnt;
  logic [2:0]       data_op;
  logic [DSIZE-1:0] data_byte;

  // Winner selection among the currently requesting channels.
  generate
    if (ARB == "FIXED") begin : g_arb_fixed
      // Lowest requesting index wins; scan downwards so the last hit is the lowest.
      always_comb begin
        winner = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
          if (ch_req[GW'(i)]) winner = GW'(i);
        end
      end
    end else begin : g_arb_rr
      // Round-robin: scan from last grant + 1, wrapping at NCH-1 back to 0.
      always_comb begin
        logic [GW:0] idx;
        logic        found;
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 1; i <= NCH; i++) begin
          idx = {1'b0, last_q} + (GW + 1)'(i);
          if (idx >= (GW + 1)'(NCH)) idx = idx - (GW + 1)'(NCH);
          if (!found && ch_req[idx[GW-1:0]]) begin
            winner = idx[GW-1:0];
            found  = 1'b1;
          end
        end
      end
    end
  endgenerate

  // Next data command: op depends on direction and on whether this is the last byte.
  always_comb begin
    wdata_sel = ch_wdata[int'(grant_q)*DSIZE +: DSIZE];
    addr_byte = DSIZE'({saddr_q, rd_q});
    next_cnt  = (state_q == S_ADDR_W) ? cnt_q : cnt_q - LSIZE'(1);
    if (rd_q) begin
      data_op   = (next_cnt == LSIZE'(1)) ? OP_RD_NACK : OP_RD_ACK;
      data_byte = '0;
    end else begin
      data_op   = OP_WRITE;
      data_byte = wdata_sel;
    end
  end

  // Transaction sequencer: next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    busy_d      = busy_q;
    rd_d        = rd_q;
    saddr_d     = saddr_q;
    cnt_d       = cnt_q;
    nack_flag_d = nack_flag_q;
    cmd_valid_d = cmd_valid_q;
    cmd_op_d    = cmd_op_q;
    cmd_data_d  = cmd_data_q;
    rdata_d     = rdata_q;
    wready_d    = '0;
    rvalid_d    = '0;
    done_d      = '0;
    nack_d      = '0;

    case (state_q)
      S_IDLE: begin
        if (|ch_req) begin
          grant_d     = winner;
          last_d      = winner;
          busy_d      = 1'b1;
          rd_d        = ch_rd[winner];
          saddr_d     = ch_saddr[int'(winner)*ASIZE +: ASIZE];
          cnt_d       = ch_len[int'(winner)*LSIZE +: LSIZE];
          nack_flag_d = 1'b0;
          cmd_valid_d = 1'b1;
          cmd_op_d    = OP_START;
          cmd_data_d  = '0;
          state_d     = S_START;
        end
      end
      S_START: begin
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = S_START_W;
        end
      end
      S_START_W: begin
        if (rsp_valid) begin
          cmd_valid_d = 1'b1;
          cmd_op_d    = OP_WRITE;
          cmd_data_d  = addr_byte;
          state_d     = S_ADDR;
        end
      end
      S_ADDR: begin
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = S_ADDR_W;
        end
      end
      S_ADDR_W: begin
        if (rsp_valid) begin
          cmd_valid_d = 1'b1;
          if (rsp_nack || cnt_q == '0) begin
            nack_flag_d = rsp_nack;
            cmd_op_d    = OP_STOP;
            cmd_data_d  = '0;
            state_d     = S_STOP;
          end else begin
            cmd_op_d    = data_op;
            cmd_data_d  = data_byte;
            state_d     = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = S_DATA_W;
          // The byte just accepted is consumed; ask the channel for the next one.
          if (!rd_q) wready_d[grant_q] = 1'b1;
        end
      end
      S_DATA_W: begin
        if (rsp_valid) begin
          cnt_d       = cnt_q - LSIZE'(1);
          cmd_valid_d = 1'b1;
          if (rd_q) begin
            rdata_d            = rsp_data;
            rvalid_d[grant_q]  = 1'b1;
          end
          if ((!rd_q && rsp_nack) || cnt_q == LSIZE'(1)) begin
            nack_flag_d = !rd_q && rsp_nack;
            cmd_op_d    = OP_STOP;
            cmd_data_d  = '0;
            state_d     = S_STOP;
          end else begin
            cmd_op_d    = data_op;
            cmd_data_d  = data_byte;
            state_d     = S_DATA;
          end
        end
      end
      S_STOP: begin
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = S_STOP_W;
        end
      end
      S_STOP_W: begin
        if (rsp_valid) begin
          done_d[grant_q] = 1'b1;
          nack_d[grant_q] = nack_flag_q;
          busy_d          = 1'b0;
          state_d         = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any transaction without issuing STOP.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      last_q      <= '0;
      busy_q      <= 1'b0;
      rd_q        <= 1'b0;
      saddr_q     <= '0;
      cnt_q       <= '0;
      nack_flag_q <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= '0;
      cmd_data_q  <= '0;
      wready_q    <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
      done_q      <= '0;
      nack_q      <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      rd_q        <= rd_d;
      saddr_q     <= saddr_d;
      cnt_q       <= cnt_d;
      nack_flag_q <= nack_flag_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_op_q    <= cmd_op_d;
      cmd_data_q  <= cmd_data_d;
      wready_q    <= wready_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      done_q      <= done_d;
      nack_q      <= nack_d;
    end
  end

  assign ch_wready = wready_q;
  assign ch_rvalid = rvalid_q;
  assign ch_rdata  = rdata_q;
  assign ch_done   = done_q;
  assign ch_nack   = nack_q;
  assign busy      = busy_q;
  assign grant_id  = grant_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_op    = cmd_op_q;
  assign cmd_data  = cmd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_multi_channel_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_multi_channel_sequencer
//  Purpose  : Self-checking bench: bit-engine model with command scoreboard,
//             table of channel transactions, plus stall, arbitration and
//             mid-transaction reset sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_i2c_multi_channel_sequencer;

  localparam int NCH = 8;
  localparam logic [2:0] OP_START = 3'd0, OP_WRITE = 3'd1, OP_RDA = 3'd2,
                         OP_RDN = 3'd3, OP_STOP = 3'd4;

  typedef struct {
    int         ch;
    bit         rd;
    logic [6:0] saddr;
    logic [7:0] len;
    logic [31:0] d;        // byte i at [i*8 +: 8]: write bytes or read responses
    int         nack_at;   // write index NACKed by slave: 0 = address, -1 = none
    int         exp_wready;
    bit         exp_nack;
  } txn_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic              rst;
  logic [NCH-1:0]    ch_req, ch_req_f, ch_rd;
  logic [NCH*7-1:0]  ch_saddr;
  logic [NCH*8-1:0]  ch_len, ch_wdata;
  logic              cmd_ready, rsp_valid, rsp_nack;
  logic [7:0]        rsp_data;
  wire  [NCH-1:0]    ch_wready, ch_rvalid, ch_done, ch_nack;
  wire  [7:0]        ch_rdata, cmd_data;
  wire               busy, cmd_valid;
  wire  [2:0]        grant_id, cmd_op;

  logic              rsp_valid_f, pend_f;
  wire  [NCH-1:0]    ch_wready_f, ch_rvalid_f, ch_done_f, ch_nack_f;
  wire  [7:0]        ch_rdata_f, cmd_data_f;
  wire               busy_f, cmd_valid_f;
  wire  [2:0]        grant_id_f, cmd_op_f;

  i2c_multi_channel_sequencer #(.NCH(NCH), .ARB("RR")) u_dut (
    .clock(clock), .rst(rst), .ch_req(ch_req), .ch_rd(ch_rd), .ch_saddr(ch_saddr),
    .ch_len(ch_len), .ch_wdata(ch_wdata), .ch_wready(ch_wready), .ch_rvalid(ch_rvalid),
    .ch_rdata(ch_rdata), .ch_done(ch_done), .ch_nack(ch_nack), .busy(busy),
    .grant_id(grant_id), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_nack(rsp_nack));

  i2c_multi_channel_sequencer #(.NCH(NCH), .ARB("FIXED")) u_fix (
    .clock(clock), .rst(rst), .ch_req(ch_req_f), .ch_rd(ch_rd), .ch_saddr(ch_saddr),
    .ch_len(ch_len), .ch_wdata(ch_wdata), .ch_wready(ch_wready_f), .ch_rvalid(ch_rvalid_f),
    .ch_rdata(ch_rdata_f), .ch_done(ch_done_f), .ch_nack(ch_nack_f), .busy(busy_f),
    .grant_id(grant_id_f), .cmd_valid(cmd_valid_f), .cmd_ready(1'b1), .cmd_op(cmd_op_f),
    .cmd_data(cmd_data_f), .rsp_valid(rsp_valid_f), .rsp_data(8'h00), .rsp_nack(1'b0));

  int n_pass = 0, n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard and model state
  logic [10:0] exp_cmd[$];     // {op, data} in issue order
  logic [7:0]  eng_rd[$];      // bytes the engine returns for reads
  logic [7:0]  exp_rd[$];      // bytes the owning channel must receive
  int          grant_log[$], grant_log_f[$];
  int          eng_wr_idx = 0, eng_nack_at = -1, stall_idx = -1, stall_left = 0;
  int          wready_cnt = 0, rvalid_cnt = 0, wbase = 0, cur_ch = 0;
  logic [31:0] cur_d = '0;

  // Requester write-data model: presents the next byte after every ch_wready.
  always_comb begin
    int k;
    k = wready_cnt - wbase;
    ch_wdata = '0;
    if (k < 4) ch_wdata[cur_ch*8 +: 8] = cur_d[k*8 +: 8];
  end

  // Bit-engine model: accepts commands (optionally stalling), checks them
  // against the scoreboard and answers one cycle later.
  initial begin
    logic       pend;
    logic [2:0] pend_op;
    logic [10:0] act;
    pend = 1'b0; pend_op = '0;
    cmd_ready = 1'b1; rsp_valid = 1'b0; rsp_data = '0; rsp_nack = 1'b0;
    forever begin
      @(negedge clock);
      rsp_valid = 1'b0;
      rsp_nack  = 1'b0;
      if (rst) begin
        pend = 1'b0;
        cmd_ready = 1'b1;
      end else begin
        if (pend) begin
          pend = 1'b0;
          rsp_valid = 1'b1;
          if (pend_op == OP_WRITE) begin
            rsp_nack = (eng_wr_idx == eng_nack_at);
            eng_wr_idx++;
          end
          if (pend_op == OP_RDA || pend_op == OP_RDN)
            rsp_data = (eng_rd.size() > 0) ? eng_rd.pop_front() : 8'hEE;
        end
        if (cmd_valid) begin
          if (cmd_op == OP_WRITE && eng_wr_idx == stall_idx && stall_left > 0) begin
            cmd_ready = 1'b0;
            stall_left--;
            if (exp_cmd.size() > 0)
              chk("stall_hold", {cmd_valid, cmd_op, cmd_data, ch_wready}, {1'b1, exp_cmd[0], 8'h00});
          end else begin
            cmd_ready = 1'b1;
            act = {cmd_op, (cmd_op == OP_WRITE) ? cmd_data : 8'h00};
            if (exp_cmd.size() == 0) chk("cmd_extra", act, 11'h7FF);
            else chk("cmd", act, exp_cmd.pop_front());
            if (cmd_op == OP_START) eng_wr_idx = 0;
            pend = 1'b1;
            pend_op = cmd_op;
          end
        end
      end
    end
  end

  // Auto-responder for the fixed-priority instance.
  initial begin
    pend_f = 1'b0; rsp_valid_f = 1'b0;
    forever begin
      @(negedge clock);
      rsp_valid_f = pend_f && !rst;
      pend_f = cmd_valid_f && !rst;
    end
  end

  // Output monitor: routing of ch_wready / ch_rvalid / ch_rdata and grant log.
  initial begin
    logic prev_busy, prev_busy_f;
    prev_busy = 1'b0; prev_busy_f = 1'b0;
    forever begin
      @(negedge clock);
      if (!rst) begin
        if (busy && !prev_busy) grant_log.push_back(int'(grant_id));
        if (busy_f && !prev_busy_f) grant_log_f.push_back(int'(grant_id_f));
        prev_busy = busy;
        prev_busy_f = busy_f;
        if (ch_wready != '0) begin
          chk("wready_ch", ch_wready, 64'(1) << cur_ch);
          wready_cnt++;
        end
        if (ch_rvalid != '0) begin
          chk("rvalid_ch", ch_rvalid, 64'(1) << cur_ch);
          rvalid_cnt++;
          if (exp_rd.size() > 0) chk("rdata", {1'b1, ch_rdata}, {1'b1, exp_rd.pop_front()});
          else chk("rdata_extra", {1'b1, ch_rdata}, 9'h000);
        end
      end
    end
  end

  task automatic start_txn(input txn_t t);
    cur_ch = t.ch;
    cur_d  = t.d;
    wbase  = wready_cnt;
    ch_rd[t.ch] = t.rd;
    ch_saddr[t.ch*7 +: 7] = t.saddr;
    ch_len[t.ch*8 +: 8]   = t.len;
    eng_nack_at = t.nack_at;
    exp_cmd.push_back({OP_START, 8'h00});
    exp_cmd.push_back({OP_WRITE, t.saddr, t.rd});
    if (t.nack_at != 0) begin
      for (int i = 0; i < int'(t.len); i++) begin
        if (t.rd) begin
          exp_cmd.push_back({(i == int'(t.len) - 1) ? OP_RDN : OP_RDA, 8'h00});
          eng_rd.push_back(t.d[i*8 +: 8]);
          exp_rd.push_back(t.d[i*8 +: 8]);
        end else begin
          exp_cmd.push_back({OP_WRITE, t.d[i*8 +: 8]});
          if (t.nack_at == i + 1) break;
        end
      end
    end
    exp_cmd.push_back({OP_STOP, 8'h00});
    ch_req[t.ch] = 1'b1;
  endtask

  task automatic run_txn(input txn_t t);
    int  wb, rb;
    bit  got;
    wb = wready_cnt;
    rb = rvalid_cnt;
    start_txn(t);
    got = 1'b0;
    for (int c = 0; c < 600 && !got; c++) begin
      @(negedge clock);
      if (ch_done != '0) got = 1'b1;
    end
    chk($sformatf("done_ch%0d", t.ch), {got, busy, ch_done, ch_nack},
        {1'b1, 1'b0, 8'(1 << t.ch), t.exp_nack ? 8'(1 << t.ch) : 8'h00});
    ch_req[t.ch] = 1'b0;
    repeat (3) @(negedge clock);
    chk($sformatf("wready_n_ch%0d", t.ch), wready_cnt - wb, t.exp_wready);
    chk($sformatf("rvalid_n_ch%0d", t.ch), rvalid_cnt - rb, t.rd ? int'(t.len) : 0);
    chk($sformatf("cmds_left_ch%0d", t.ch), exp_cmd.size(), 0);
  endtask

  txn_t vec[6];
  txn_t tv;

  initial begin
    int ord[4];
    int ndone;
    vec[0] = '{2, 1'b0, 7'h50, 8'd2, 32'h0000_3CA5, -1, 2, 1'b0};
    vec[1] = '{5, 1'b1, 7'h50, 8'd3, 32'h0033_2211, -1, 0, 1'b0};
    vec[2] = '{0, 1'b0, 7'h42, 8'd4, 32'h4433_2211,  0, 0, 1'b1};
    vec[3] = '{7, 1'b0, 7'h2A, 8'd3, 32'h00C3_B2A1,  2, 2, 1'b1};
    vec[4] = '{3, 1'b0, 7'h3F, 8'd0, 32'h0000_0000, -1, 0, 1'b0};
    vec[5] = '{4, 1'b1, 7'h7F, 8'd1, 32'h0000_005A, -1, 0, 1'b0};

    rst = 1'b1; ch_req = '0; ch_req_f = '0; ch_rd = '0; ch_saddr = '0; ch_len = '0;
    repeat (3) @(negedge clock);
    chk("reset_busy", busy, 1'b0);
    chk("reset_outs", {cmd_valid, cmd_op, cmd_data, grant_id, ch_wready, ch_rvalid,
                       ch_rdata, ch_done, ch_nack}, 64'h0);
    rst = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 6; i++) run_txn(vec[i]);

    // cmd_ready held low for 5 cycles on the second WRITE (first data byte)
    tv = '{6, 1'b0, 7'h12, 8'd2, 32'h0000_C35A, -1, 2, 1'b0};
    stall_idx = 1; stall_left = 5;
    run_txn(tv);
    chk("stall_consumed", stall_left, 0);
    stall_idx = -1;

    // Round-robin with channels 1, 3, 6 requesting continuously (last grant was 6)
    ord = '{1, 3, 6, 1};
    foreach (ord[i]) begin
      ch_rd[ord[i]] = 1'b0;
      ch_len[ord[i]*8 +: 8] = 8'd0;
      ch_saddr[ord[i]*7 +: 7] = 7'(ord[i] * 17);
    end
    eng_nack_at = -1;
    foreach (ord[i]) begin
      exp_cmd.push_back({OP_START, 8'h00});
      exp_cmd.push_back({OP_WRITE, 7'(ord[i] * 17), 1'b0});
      exp_cmd.push_back({OP_STOP, 8'h00});
    end
    grant_log.delete();
    ndone = 0;
    ch_req = 8'b0100_1010;
    for (int c = 0; c < 400 && ndone < 4; c++) begin
      @(negedge clock);
      if (ch_done != '0) ndone++;
    end
    ch_req = '0;
    repeat (4) @(negedge clock);
    chk("rr_done_count", ndone, 4);
    chk("rr_grant_count", grant_log.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("rr_grant%0d", i), (grant_log.size() > i) ? grant_log[i] : -1, ord[i]);
    chk("rr_cmds_left", exp_cmd.size(), 0);

    // Fixed priority: lowest index (1) keeps winning
    grant_log_f.delete();
    ch_req_f = 8'b0100_1010;
    for (int c = 0; c < 300 && grant_log_f.size() < 3; c++) @(negedge clock);
    ch_req_f = '0;
    chk("fix_grant_count", grant_log_f.size(), 3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("fix_grant%0d", i), (grant_log_f.size() > i) ? grant_log_f[i] : -1, 1);
    repeat (30) @(negedge clock);

    // Reset during read byte 2, then a fresh request on ch4
    tv = '{3, 1'b1, 7'h21, 8'd3, 32'h0099_8877, -1, 0, 1'b0};
    begin
      int rb;
      bit got;
      rb = rvalid_cnt;
      got = 1'b0;
      start_txn(tv);
      for (int c = 0; c < 200 && !got; c++) begin
        @(negedge clock);
        if (rvalid_cnt == rb + 1) got = 1'b1;
      end
      chk("rst_reached_byte2", got, 1'b1);
    end
    #1 rst = 1'b1;
    ch_req = '0;
    @(negedge clock);
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_outs", {cmd_valid, cmd_op, cmd_data, grant_id, ch_wready, ch_rvalid,
                          ch_rdata, ch_done, ch_nack}, 64'h0);
    #1 rst = 1'b0;
    exp_cmd.delete(); eng_rd.delete(); exp_rd.delete();
    @(negedge clock);
    tv = '{4, 1'b0, 7'h30, 8'd1, 32'h0000_0077, -1, 1, 1'b0};
    run_txn(tv);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
